// File: rtl/nr_div_ctrl.sv
// Control FSM sequencing a 4-bit non-restoring divider: INIT, four ITER cycles, then DONE.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with an error flag.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; strobes low; done may be held (DONE_PULSE=0)
//  INIT   | A <= 0, Q <= dividend
//  ITER   | shift A:Q, add/sub divisor, count; last pass captures results
//  DONE   | one-cycle completion, busy low, done high
module nr_div_ctrl #(
   parameter bit DONE_PULSE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic negative_flag,
   input  logic status,
   input  logic divisor_zero,
   output logic busy,
   output logic done,
   output logic div_by_zero,
   output logic select_A,
   output logic select_Q,
   output logic ld_A,
   output logic ld_Q,
   output logic shift_left_enable_a,
   output logic shift_left_enable_q,
   output logic select_add,
   output logic select_mux_2,
   output logic count_enable,
   output logic ld_rem_quotient
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   logic   r_busy;
   logic   r_done;
   logic   r_select_A;
   logic   r_select_Q;
   logic   r_ld_A;
   logic   r_ld_Q;
   logic   r_shift_a;
   logic   r_shift_q;
   logic   r_select_add;
   logic   r_count_enable;
   logic   w_in_iter;

`ifdef DIV_ZERO_DETECT_EN
   logic   r_div_by_zero;
`else
   logic   w_unused_divisor_zero;
   assign w_unused_divisor_zero = divisor_zero;
`endif

   // Strobes are registered for the state being entered, so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_select_A     <= 1'b0;
         r_select_Q     <= 1'b0;
         r_ld_A         <= 1'b0;
         r_ld_Q         <= 1'b0;
         r_shift_a      <= 1'b0;
         r_shift_q      <= 1'b0;
         r_select_add   <= 1'b0;
         r_count_enable <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         r_div_by_zero  <= 1'b0;
`endif
      end else begin
         r_busy         <= 1'b0;
         r_select_A     <= 1'b0;
         r_select_Q     <= 1'b0;
         r_ld_A         <= 1'b0;
         r_ld_Q         <= 1'b0;
         r_shift_a      <= 1'b0;
         r_shift_q      <= 1'b0;
         r_select_add   <= 1'b0;
         r_count_enable <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                  if (divisor_zero) begin
                     r_state       <= S_DONE;
                     r_done        <= 1'b1;
                     r_div_by_zero <= 1'b1;
                  end else begin
                     r_state       <= S_INIT;
                     r_busy        <= 1'b1;
                     r_done        <= 1'b0;
                     r_ld_A        <= 1'b1;
                     r_ld_Q        <= 1'b1;
                     r_div_by_zero <= 1'b0;
                  end
`else
                  r_state <= S_INIT;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_ld_A  <= 1'b1;
                  r_ld_Q  <= 1'b1;
`endif
               end
            end
            S_INIT: begin
               r_state        <= S_ITER;
               r_busy         <= 1'b1;
               r_select_A     <= 1'b1;
               r_select_Q     <= 1'b1;
               r_ld_A         <= 1'b1;
               r_ld_Q         <= 1'b1;
               r_shift_a      <= 1'b1;
               r_shift_q      <= 1'b1;
               r_select_add   <= 1'b1;
               r_count_enable <= 1'b1;
            end
            S_ITER: begin
               // The datapath counter reads 3 on the fourth pass; its 4th increment wraps it to 0.
               if (status) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state        <= S_ITER;
                  r_busy         <= 1'b1;
                  r_select_A     <= 1'b1;
                  r_select_Q     <= 1'b1;
                  r_ld_A         <= 1'b1;
                  r_ld_Q         <= 1'b1;
                  r_shift_a      <= 1'b1;
                  r_shift_q      <= 1'b1;
                  r_select_add   <= 1'b1;
                  r_count_enable <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= ~DONE_PULSE;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign w_in_iter = (r_state == S_ITER);

   assign busy                = r_busy;
   assign done                = r_done;
   assign select_A            = r_select_A;
   assign select_Q            = r_select_Q;
   assign ld_A                = r_ld_A;
   assign ld_Q                = r_ld_Q;
   assign shift_left_enable_a = r_shift_a;
   assign shift_left_enable_q = r_shift_q;
   assign select_add          = r_select_add;
   assign count_enable        = r_count_enable;
   // Sign of the current partial remainder picks add (negative) or subtract.
   assign select_mux_2        = w_in_iter & ~negative_flag;
   assign ld_rem_quotient     = w_in_iter & status;

`ifdef DIV_ZERO_DETECT_EN
   assign div_by_zero = r_div_by_zero;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_nr_div_ctrl.sv
// Bench for nr_div_ctrl: a 4-bit non-restoring datapath model driven by the DUT strobes,
// plus a phase-count model of the expected handshake/strobe outputs checked every cycle.
module tb_nr_div_ctrl;
   localparam bit DP = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic divisor_zero = 1'b0;
   logic negative_flag, status;
   logic busy, done, div_by_zero, select_A, select_Q, ld_A, ld_Q;
   logic shift_left_enable_a, shift_left_enable_q, select_add, select_mux_2;
   logic count_enable, ld_rem_quotient;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   nr_div_ctrl #(.DONE_PULSE(DP)) dut (
      .clk(clk), .rst(rst), .start(start), .negative_flag(negative_flag),
      .status(status), .divisor_zero(divisor_zero), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .select_A(select_A), .select_Q(select_Q),
      .ld_A(ld_A), .ld_Q(ld_Q), .shift_left_enable_a(shift_left_enable_a),
      .shift_left_enable_q(shift_left_enable_q), .select_add(select_add),
      .select_mux_2(select_mux_2), .count_enable(count_enable),
      .ld_rem_quotient(ld_rem_quotient)
   );

   // Datapath model: A (5b), Q (4b), divisor M, 2-bit iteration counter
   logic [3:0] dividend = 4'd0;
   logic [3:0] divisor = 4'd0;
   logic [4:0] dp_a = 5'd0;
   logic [3:0] dp_q = 4'd0;
   logic [1:0] dp_cnt = 2'd0;
   logic [4:0] cap_r = 5'd0;
   logic [3:0] cap_q = 4'd0;
   bit         cap_valid = 1'b0;
   logic [4:0] sh_a, alu;

   assign negative_flag = dp_a[4];
   assign status = (dp_cnt == 2'd3);
   assign sh_a = {dp_a[3:0], dp_q[3]};
   assign alu = select_mux_2 ? (sh_a - {1'b0, divisor}) : (sh_a + {1'b0, divisor});

   always @(posedge clk) begin
      if (rst) dp_cnt <= 2'd0;
      else if (count_enable) dp_cnt <= dp_cnt + 2'd1;
      if (ld_A) dp_a <= select_A ? alu : 5'd0;
      if (ld_Q) dp_q <= select_Q ? {dp_q[2:0], ~alu[4]} : dividend;
      if (ld_rem_quotient) begin
         cap_r <= alu;
         cap_q <= {dp_q[2:0], ~alu[4]};
         cap_valid <= 1'b1;
      end
   end

   // Controller model: phase 0 idle, 1 init, 2..5 iterations, 6 done
   int m_phase = 0;
   bit m_done_hold = 1'b0;
   bit m_dz = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_done_hold <= 1'b0;
         m_dz <= 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_done_hold <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            m_dz <= divisor_zero;
            m_phase <= divisor_zero ? 6 : 1;
`else
            m_phase <= 1;
`endif
         end
      end else if (m_phase == 6) begin
         m_phase <= 0;
         m_done_hold <= (DP == 1'b0);
      end else begin
         m_phase <= m_phase + 1;
      end
   end

   int en_cnt = 0;
   always @(negedge clk) begin
      logic [13:0] act, exp_v;
      bit iter, act_ld;
      if (chk_en) begin
         iter = (m_phase >= 2) && (m_phase <= 5);
         act_ld = (m_phase >= 1) && (m_phase <= 5);
         exp_v[13] = act_ld;
         exp_v[12] = (m_phase == 6) || (m_phase == 0 && m_done_hold);
`ifdef DIV_ZERO_DETECT_EN
         exp_v[11] = m_dz;
`else
         exp_v[11] = 1'b0;
`endif
         exp_v[10] = iter;
         exp_v[9]  = iter;
         exp_v[8]  = act_ld;
         exp_v[7]  = act_ld;
         exp_v[6]  = iter;
         exp_v[5]  = iter;
         exp_v[4]  = iter;
         exp_v[3]  = iter & ~negative_flag;
         exp_v[2]  = iter;
         exp_v[1]  = (m_phase == 5);
         exp_v[0]  = 1'b0;
         act = {busy, done, div_by_zero, select_A, select_Q, ld_A, ld_Q,
                shift_left_enable_a, shift_left_enable_q, select_add,
                select_mux_2, count_enable, ld_rem_quotient, 1'b0};
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t phase=%0d got=%b expected=%b", $time, m_phase, act, exp_v);
         end
         if (m_phase == 1) begin
            en_cnt = 0;
            checks++;
            if (dp_cnt !== 2'd0) begin
               errors++;
               $display("FAIL counter_at_init got=%0d expected=0", dp_cnt);
            end
         end
         if (count_enable === 1'b1) en_cnt++;
         if (ld_rem_quotient === 1'b1) begin
            checks++;
            if (en_cnt != 4) begin
               errors++;
               $display("FAIL count_pulses got=%0d expected=4", en_cnt);
            end
         end
      end
   end

   task automatic check_eq(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   task automatic run_div(input logic [3:0] dd, input logic [3:0] dv, input bit hold,
                          output int lat);
      bit found;
      @(posedge clk); #1;
      dividend = dd; divisor = dv; divisor_zero = (dv == 4'd0);
      cap_valid = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      found = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            found = 1'b1;
            lat = i;
         end
      end
      start = 1'b0;
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL done_timeout dividend=%0d divisor=%0d got=none expected=done", dd, dv);
      end
   endtask

   task automatic check_result(input string name, input logic [3:0] dd, input logic [3:0] dv);
      logic [4:0] r;
      r = cap_r;
      if (r[4]) r = r + {1'b0, dv};
      check_eq({name, "_valid"}, int'(cap_valid), 1);
      check_eq({name, "_quot"}, int'(cap_q), int'(dd) / int'(dv));
      check_eq({name, "_rem"}, int'(r), int'(dd) % int'(dv));
   endtask

   task automatic rst_mid(input logic [3:0] dd, input logic [3:0] dv, input int k);
      @(posedge clk); #1;
      dividend = dd; divisor = dv; divisor_zero = (dv == 4'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (k) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int lat;
      logic [3:0] dd, dv;
      int mode;
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("reset_outputs", int'({busy, done, div_by_zero, select_A, select_Q, ld_A, ld_Q,
               shift_left_enable_a, shift_left_enable_q, select_add, select_mux_2,
               count_enable, ld_rem_quotient}), 0);

      run_div(4'd13, 4'd3, 1'b0, lat);
      check_eq("lat_13_3", lat, 6);
      check_eq("quot_13_3", int'(cap_q), 4);
      check_eq("rawrem_13_3", int'(cap_r), 30);
      check_result("r13_3", 4'd13, 4'd3);

      run_div(4'd7, 4'd2, 1'b0, lat);
      check_eq("quot_7_2", int'(cap_q), 3);
      check_result("r7_2", 4'd7, 4'd2);
      run_div(4'd8, 4'd3, 1'b0, lat);
      check_eq("quot_8_3", int'(cap_q), 2);
      check_result("r8_3", 4'd8, 4'd3);

      run_div(4'd15, 4'd4, 1'b1, lat);
      check_eq("lat_hold", lat, 6);
      check_result("rhold", 4'd15, 4'd4);

      rst_mid(4'd9, 4'd2, 2);
      @(negedge clk);
      check_eq("rst_mid_idle", int'({busy, done, ld_A, count_enable}), 0);
      run_div(4'd13, 4'd3, 1'b0, lat);
      check_result("r13_3_after_rst", 4'd13, 4'd3);

      run_div(4'd11, 4'd0, 1'b0, lat);
`ifdef DIV_ZERO_DETECT_EN
      check_eq("lat_div0", lat, 1);
      check_eq("div_by_zero_flag", int'(div_by_zero), 1);
      check_eq("div0_no_capture", int'(cap_valid), 0);
      run_div(4'd13, 4'd3, 1'b0, lat);
      check_eq("div_by_zero_cleared", int'(div_by_zero), 0);
      check_result("r_after_div0", 4'd13, 4'd3);
`else
      check_eq("lat_div0", lat, 6);
      check_eq("div_by_zero_tied", int'(div_by_zero), 0);
`endif

      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         dd = 4'($urandom_range(0, 15));
         dv = 4'($urandom_range(0, 15));
         mode = $urandom_range(0, 9);
         if (mode == 0) begin
            rst_mid(dd, (dv == 4'd0) ? 4'd1 : dv, $urandom_range(0, 5));
         end else begin
            run_div(dd, dv, mode[0], lat);
`ifdef DIV_ZERO_DETECT_EN
            check_eq("rand_lat", lat, (dv == 4'd0) ? 1 : 6);
`else
            check_eq("rand_lat", lat, 6);
`endif
            if (dv != 4'd0) check_result("rand", dd, dv);
         end
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
